// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier C = A * B: element-wise operand load, one MAC per cycle,
// row-major result stream over a valid/ready port.
module matrix_mul_seq #(
  parameter int unsigned ROW1   = 3,
  parameter int unsigned COL1   = 3,
  parameter int unsigned COL2   = 3,
  parameter int unsigned WIDTH  = 16,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned N1   = ROW1 * COL1,
  localparam int unsigned N2   = COL1 * COL2,
  localparam int unsigned N3   = ROW1 * COL2,
  localparam int unsigned NMAX = (N1 > N2) ? N1 : N2,
  localparam int unsigned AW   = $clog2((NMAX > 2) ? NMAX : 2),
  localparam int unsigned RW   = $clog2((N3 > 2) ? N3 : 2),
  localparam int unsigned ACCW = 2 * WIDTH + $clog2((COL1 > 2) ? COL1 : 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACCW-1:0]  res_data,
  output logic [RW-1:0]    res_idx
);

  localparam int unsigned AIW = $clog2((N1 > 2) ? N1 : 2);
  localparam int unsigned BIW = $clog2((N2 > 2) ? N2 : 2);
  localparam int unsigned IW  = $clog2((ROW1 > 2) ? ROW1 : 2);
  localparam int unsigned JW  = $clog2((COL2 > 2) ? COL2 : 2);
  localparam int unsigned KW  = $clog2((COL1 > 2) ? COL1 : 2);
  localparam int unsigned EXT = ACCW - 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem_a [N1];
  logic [WIDTH-1:0]   mem_b [N2];
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [KW-1:0]      k;
  logic [ACCW-1:0]    acc;
  logic [AIW-1:0]     a_idx;
  logic [BIW-1:0]     b_idx;
  logic [WIDTH-1:0]   a_el;
  logic [WIDTH-1:0]   b_el;
  logic [2*WIDTH-1:0] op_a;
  logic [2*WIDTH-1:0] op_b;
  logic [2*WIDTH-1:0] prod;
  logic [ACCW-1:0]    prod_ext;
  logic [ACCW-1:0]    acc_sum;
  logic               last_ij;

  // Operand storage: no reset, writable only while idle, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    if (ld_en && state == IDLE) begin
      if (!ld_sel) begin
        if (32'(ld_addr) < N1) mem_a[AIW'(ld_addr)] <= ld_data;
      end else begin
        if (32'(ld_addr) < N2) mem_b[BIW'(ld_addr)] <= ld_data;
      end
    end
  end

  // Operand fetch and MAC datapath; low 2*WIDTH product bits are exact for both modes
  always_comb begin
    a_idx    = AIW'(32'(i) * COL1 + 32'(k));
    b_idx    = BIW'(32'(k) * COL2 + 32'(j));
    a_el     = mem_a[a_idx];
    b_el     = mem_b[b_idx];
    op_a     = SIGNED ? {{WIDTH{a_el[WIDTH-1]}}, a_el} : {{WIDTH{1'b0}}, a_el};
    op_b     = SIGNED ? {{WIDTH{b_el[WIDTH-1]}}, b_el} : {{WIDTH{1'b0}}, b_el};
    prod     = op_a * op_b;
    prod_ext = SIGNED ? {{EXT{prod[2*WIDTH-1]}}, prod} : {{EXT{1'b0}}, prod};
    acc_sum  = ((k == '0) ? '0 : acc) + prod_ext;
    last_ij  = (i == IW'(ROW1 - 1)) && (j == JW'(COL2 - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end
        end
        CALC: begin
          if (k == KW'(COL1 - 1)) begin
            res_data  <= acc_sum;
            res_idx   <= RW'(32'(i) * COL2 + 32'(j));
            res_valid <= 1'b1;
            k         <= '0;
            state     <= OUT;
          end else begin
            acc <= acc_sum;
            k   <= k + 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_ij) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              i     <= '0;
              j     <= '0;
              state <= IDLE;
            end else begin
              if (j == JW'(COL2 - 1)) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed bench for matrix_mul_seq: default unsigned 3x3, signed 3x3 and a 2x4 * 4x1 instance.
module tb_matrix_mul_seq;

  logic        clk;
  logic        rst;
  logic        ld_sel;
  logic [15:0] ld_data;
  logic [3:0]  ld_addr;
  logic [2:0]  ld_addr2;
  logic        ld_en0, ld_en1, ld_en2;
  logic        start0, start1, start2;
  logic        ready0, ready1, ready2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        valid0, valid1, valid2;
  logic [33:0] data0, data1, data2;
  logic [3:0]  idx0, idx1;
  logic [0:0]  idx2;

  logic [33:0] exp_c [9];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  matrix_mul_seq u_dut0 (
    .clk(clk), .rst(rst), .ld_en(ld_en0), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start0), .busy(busy0), .done(done0),
    .res_valid(valid0), .res_ready(ready0), .res_data(data0), .res_idx(idx0)
  );

  matrix_mul_seq #(.SIGNED(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en1), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start1), .busy(busy1), .done(done1),
    .res_valid(valid1), .res_ready(ready1), .res_data(data1), .res_idx(idx1)
  );

  matrix_mul_seq #(.ROW1(2), .COL1(4), .COL2(1)) u_dut2 (
    .clk(clk), .rst(rst), .ld_en(ld_en2), .ld_sel(ld_sel), .ld_addr(ld_addr2),
    .ld_data(ld_data), .start(start2), .busy(busy2), .done(done2),
    .res_valid(valid2), .res_ready(ready2), .res_data(data2), .res_idx(idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int dut, input logic sel, input int addr, input logic [15:0] d);
    @(negedge clk);
    ld_sel   = sel;
    ld_data  = d;
    ld_addr  = 4'(addr);
    ld_addr2 = 3'(addr);
    case (dut)
      0: ld_en0 = 1'b1;
      1: ld_en1 = 1'b1;
      default: ld_en2 = 1'b1;
    endcase
    @(negedge clk);
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
    ld_en2 = 1'b0;
  endtask

  task automatic pulse_start(input int dut);
    @(negedge clk);
    case (dut)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    case (dut)
      0: check("busy_after_start0", 64'(busy0), 64'(1));
      1: check("busy_after_start1", 64'(busy1), 64'(1));
      default: check("busy_after_start2", 64'(busy2), 64'(1));
    endcase
  endtask

  // Collect results first..last (consumer ready high), checking value and index of each
  task automatic stream(input int dut, input int first, input int last);
    logic        v;
    logic [33:0] d;
    logic [3:0]  x;
    for (int r = first; r <= last; r++) begin
      for (int t = 0; t < 40; t++) begin
        v = (dut == 0) ? valid0 : (dut == 1) ? valid1 : valid2;
        if (v) break;
        @(negedge clk);
      end
      d = (dut == 0) ? data0 : (dut == 1) ? data1 : data2;
      x = (dut == 0) ? idx0 : (dut == 1) ? idx1 : 4'(idx2);
      check($sformatf("valid_d%0d_r%0d", dut, r), 64'(v), 64'(1));
      check($sformatf("data_d%0d_r%0d", dut, r), 64'(d), 64'(exp_c[r]));
      check($sformatf("idx_d%0d_r%0d", dut, r), 64'(x), 64'(r));
      @(negedge clk);
    end
  endtask

  // Call right after the final handshake: done high for exactly one cycle, busy low
  task automatic check_done(input int dut);
    logic dn, bz;
    dn = (dut == 0) ? done0 : (dut == 1) ? done1 : done2;
    bz = (dut == 0) ? busy0 : (dut == 1) ? busy1 : busy2;
    check($sformatf("done_pulse_d%0d", dut), 64'(dn), 64'(1));
    check($sformatf("busy_low_d%0d", dut), 64'(bz), 64'(0));
    @(negedge clk);
    dn = (dut == 0) ? done0 : (dut == 1) ? done1 : done2;
    check($sformatf("done_drop_d%0d", dut), 64'(dn), 64'(0));
  endtask

  task automatic set_t1_expect();
    exp_c[0] = 34'd126; exp_c[1] = 34'd132; exp_c[2] = 34'd138;
    exp_c[3] = 34'd306; exp_c[4] = 34'd321; exp_c[5] = 34'd336;
    exp_c[6] = 34'd486; exp_c[7] = 34'd510; exp_c[8] = 34'd534;
  endtask

  initial begin
    rst = 1'b1;
    ld_sel = 1'b0; ld_data = '0; ld_addr = '0; ld_addr2 = '0;
    ld_en0 = 1'b0; ld_en1 = 1'b0; ld_en2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'(0));
    check("rst_done", 64'(done0), 64'(0));
    check("rst_valid", 64'(valid0), 64'(0));
    check("rst_data", 64'(data0), 64'(0));
    check("rst_idx", 64'(idx0), 64'(0));
    rst = 1'b0;

    // T1: A = 1..9, B = 0x11..0x19; address 9 of A is out of range and must be dropped
    for (int n = 0; n < 9; n++) load(0, 1'b0, n, 16'(n + 1));
    for (int n = 0; n < 9; n++) load(0, 1'b1, n, 16'(17 + n));
    load(0, 1'b0, 9, 16'hDEAD);
    set_t1_expect();
    pulse_start(0);
    stream(0, 0, 8);
    check_done(0);

    // T4: backpressure at first result, with start and loads attempted while busy
    ready0 = 1'b0;
    pulse_start(0);
    for (int t = 0; t < 40 && !valid0; t++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold_valid_%0d", c), 64'(valid0), 64'(1));
      check($sformatf("hold_data_%0d", c), 64'(data0), 64'(34'h7E));
      check($sformatf("hold_idx_%0d", c), 64'(idx0), 64'(0));
      start0   = 1'b1;
      ld_en0   = 1'b1;
      ld_sel   = (c % 2) == 1;
      ld_addr  = 4'(c);
      ld_data  = 16'h00FF;
      @(negedge clk);
    end
    start0 = 1'b0;
    ld_en0 = 1'b0;
    ready0 = 1'b1;
    @(negedge clk);
    stream(0, 1, 8);
    check_done(0);

    // T5: reset while idx 4 is being computed, then a full recompute from retained operands
    pulse_start(0);
    stream(0, 0, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy0), 64'(0));
    check("midrst_done", 64'(done0), 64'(0));
    check("midrst_valid", 64'(valid0), 64'(0));
    check("midrst_data", 64'(data0), 64'(0));
    check("midrst_idx", 64'(idx0), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pulse_start(0);
    stream(0, 0, 8);
    check_done(0);

    // T2: unsigned maxima, 3 * 0xFFFF^2 needs all 34 bits
    for (int n = 0; n < 9; n++) load(0, 1'b0, n, 16'hFFFF);
    for (int n = 0; n < 9; n++) load(0, 1'b1, n, 16'hFFFF);
    for (int n = 0; n < 9; n++) exp_c[n] = 34'h2_FFFA_0003;
    pulse_start(0);
    stream(0, 0, 8);
    check_done(0);

    // T3: signed, (-1) * 2 summed three times = -6
    for (int n = 0; n < 9; n++) load(1, 1'b0, n, 16'hFFFF);
    for (int n = 0; n < 9; n++) load(1, 1'b1, n, 16'h0002);
    for (int n = 0; n < 9; n++) exp_c[n] = 34'h3_FFFF_FFFA;
    pulse_start(1);
    stream(1, 0, 8);
    check_done(1);

    // T6: 2x4 * 4x1; B address 5 is beyond N2 and would alias B[1] if not dropped
    for (int n = 0; n < 8; n++) load(2, 1'b0, n, 16'(n + 1));
    for (int n = 0; n < 4; n++) load(2, 1'b1, n, 16'(n + 1));
    load(2, 1'b1, 5, 16'd99);
    exp_c[0] = 34'd30;
    exp_c[1] = 34'd70;
    pulse_start(2);
    stream(2, 0, 1);
    check_done(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
